// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jump sequencer: operand forwarding selects, load/ALU hazard
// stalls, taken-transfer redirect/flush, and branch performance counters.
module branch_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_stall,
  input  logic                  id_branch,
  input  logic                  id_jal,
  input  logic                  id_jalr,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_regwrite,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  cmp_taken,
  output logic [1:0]            fwd_rs1,
  output logic [1:0]            fwd_rs2,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic                  redirect,
  output logic                  flush_if_id,
  output logic [CNT_W-1:0]      cnt_branch,
  output logic [CNT_W-1:0]      cnt_taken,
  output logic [CNT_W-1:0]      cnt_stall
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LDWAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  logic use_rs1, use_rs2;
  logic ex_hit, mem_hit;
  logic hz2, hz1;
  logic is_ctrl, taken;
  logic mem_fwd_ok;

  // x0 is hard-wired zero, so it never creates a dependency
  function automatic logic src_hit(input logic                  used,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] rd);
    return used && (src != '0) && (src == rd);
  endfunction

  assign use_rs1    = id_branch | id_jalr;
  assign use_rs2    = id_branch;
  assign ex_hit     = src_hit(use_rs1, id_rs1, ex_rd)  | src_hit(use_rs2, id_rs2, ex_rd);
  assign mem_hit    = src_hit(use_rs1, id_rs1, mem_rd) | src_hit(use_rs2, id_rs2, mem_rd);
  assign hz2        = ex_regwrite & ex_memread & ex_hit;
  assign hz1        = ~hz2 & ((ex_regwrite & ~ex_memread & ex_hit) |
                              (mem_regwrite & mem_memread & mem_hit));
  assign is_ctrl    = id_branch | id_jal | id_jalr;
  assign taken      = (id_branch & cmp_taken) | id_jal | id_jalr;
  assign mem_fwd_ok = mem_regwrite & ~mem_memread;

  // Compare operand source: EX/MEM ALU result beats MEM/WB write data
  always_comb begin
    fwd_rs1 = 2'd0;
    fwd_rs2 = 2'd0;
    if (mem_fwd_ok && src_hit(use_rs1, id_rs1, mem_rd)) begin
      fwd_rs1 = 2'd1;
    end else if (wb_regwrite && src_hit(use_rs1, id_rs1, wb_rd)) begin
      fwd_rs1 = 2'd2;
    end
    if (mem_fwd_ok && src_hit(use_rs2, id_rs2, mem_rd)) begin
      fwd_rs2 = 2'd1;
    end else if (wb_regwrite && src_hit(use_rs2, id_rs2, wb_rd)) begin
      fwd_rs2 = 2'd2;
    end
  end

  // Next state, pipeline controls and counter updates; all frozen by bus_stall
  always_comb begin
    state_d      = state_q;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    redirect     = 1'b0;
    flush_if_id  = 1'b0;
    cnt_branch_d = cnt_branch_q;
    cnt_taken_d  = cnt_taken_q;
    cnt_stall_d  = cnt_stall_q;
    if (!rst && !bus_stall) begin
      case (state_q)
        IDLE: begin
          if (hz2 || hz1) begin
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            cnt_stall_d  = cnt_stall_q + CNT_W'(1);
            if (hz2) begin
              state_d = LDWAIT;
            end
          end else if (is_ctrl) begin
            cnt_branch_d = cnt_branch_q + CNT_W'(1);
            if (taken) begin
              redirect    = 1'b1;
              flush_if_id = 1'b1;
              cnt_taken_d = cnt_taken_q + CNT_W'(1);
            end
          end
        end
        LDWAIT: begin
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          cnt_stall_d  = cnt_stall_q + CNT_W'(1);
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  assign cnt_branch = cnt_branch_q;
  assign cnt_taken  = cnt_taken_q;
  assign cnt_stall  = cnt_stall_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed scenarios then random traffic, all
// checked against a cycle-level behavioural model of the ID-stage rules.
module tb_branch_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, bus_stall, id_branch, id_jal, id_jalr;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic          ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, cmp_taken;
  logic [1:0]    fwd_rs1, fwd_rs2;
  logic          stall_if_id, bubble_id_ex, redirect, flush_if_id;
  logic [CW-1:0] cnt_branch, cnt_taken, cnt_stall;

  branch_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus_stall(bus_stall),
    .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .cmp_taken(cmp_taken),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .redirect(redirect), .flush_if_id(flush_if_id),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken), .cnt_stall(cnt_stall)
  );

  int vectors = 0;
  int errs    = 0;

  // Reference model: remaining forced stall cycles after a load-use hit, plus counters
  int            m_wait_left;
  logic [CW-1:0] m_branch, m_taken, m_stall;

  // Values seen at the most recent sample point, for directed checks
  logic          o_stall, o_redirect, o_flush;
  logic [1:0]    o_f1, o_f2;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit dep(input bit used, input logic [RW-1:0] s, input logic [RW-1:0] rd);
    return used && (s != 0) && (s == rd);
  endfunction

  function automatic logic [1:0] exp_fwd(input bit used, input logic [RW-1:0] s);
    if (mem_regwrite && !mem_memread && dep(used, s, mem_rd)) return 2'd1;
    if (wb_regwrite && dep(used, s, wb_rd)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic idle_inputs();
    rst = 0; bus_stall = 0; id_branch = 0; id_jal = 0; id_jalr = 0;
    id_rs1 = 0; id_rs2 = 0; ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0; wb_regwrite = 0; wb_rd = 0;
    cmp_taken = 0;
  endtask

  // One clock: predict, sample at negedge, compare, then advance the model
  task automatic cycle(input string tag);
    bit u1, u2, load_use, alu_dep, stall_e, redir_e;
    bit inc_b, inc_t, inc_s;
    logic [1:0] f1_e, f2_e;
    u1 = id_branch || id_jalr;
    u2 = id_branch;
    load_use = ex_regwrite && ex_memread && (dep(u1, id_rs1, ex_rd) || dep(u2, id_rs2, ex_rd));
    alu_dep  = (ex_regwrite && !ex_memread && (dep(u1, id_rs1, ex_rd) || dep(u2, id_rs2, ex_rd))) ||
               (mem_regwrite && mem_memread && (dep(u1, id_rs1, mem_rd) || dep(u2, id_rs2, mem_rd)));
    stall_e = 0; redir_e = 0; inc_b = 0; inc_t = 0; inc_s = 0;
    if (!rst && !bus_stall) begin
      if (m_wait_left > 0 || load_use || alu_dep) begin
        stall_e = 1; inc_s = 1;
      end else if (id_branch || id_jal || id_jalr) begin
        inc_b   = 1;
        redir_e = (id_branch && cmp_taken) || id_jal || id_jalr;
        inc_t   = redir_e;
      end
    end
    f1_e = exp_fwd(u1, id_rs1);
    f2_e = exp_fwd(u2, id_rs2);
    @(negedge clk);
    o_stall = stall_if_id; o_redirect = redirect; o_flush = flush_if_id;
    o_f1 = fwd_rs1; o_f2 = fwd_rs2;
    chk({tag, ".stall"},    CW'(stall_if_id),  CW'(stall_e));
    chk({tag, ".bubble"},   CW'(bubble_id_ex), CW'(stall_e));
    chk({tag, ".redirect"}, CW'(redirect),     CW'(redir_e));
    chk({tag, ".flush"},    CW'(flush_if_id),  CW'(redir_e));
    chk({tag, ".fwd1"},     CW'(fwd_rs1),      CW'(f1_e));
    chk({tag, ".fwd2"},     CW'(fwd_rs2),      CW'(f2_e));
    chk({tag, ".cbr"},      cnt_branch,        m_branch);
    chk({tag, ".ctk"},      cnt_taken,         m_taken);
    chk({tag, ".cst"},      cnt_stall,         m_stall);
    @(posedge clk);
    if (rst) begin
      m_wait_left = 0; m_branch = 0; m_taken = 0; m_stall = 0;
    end else if (!bus_stall) begin
      if (m_wait_left > 0) m_wait_left = m_wait_left - 1;
      else if (load_use)   m_wait_left = 1;
      m_branch = m_branch + CW'(inc_b);
      m_taken  = m_taken + CW'(inc_t);
      m_stall  = m_stall + CW'(inc_s);
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle("rst");
    rst = 0;
  endtask

  initial begin
    m_wait_left = 0; m_branch = 0; m_taken = 0; m_stall = 0;
    idle_inputs();
    #1;
    do_reset();

    // Reset state
    cycle("reset_idle");
    chk("reset_cnt_branch", cnt_branch, 0);
    chk("reset_stall", CW'(o_stall), 0);

    // beq x1,x2 behind an ALU writer of x1: one stall, then EX/MEM forward
    do_reset();
    id_branch = 1; id_rs1 = 1; id_rs2 = 2; ex_regwrite = 1; ex_rd = 1; cmp_taken = 1;
    cycle("hz1_c0");
    chk("hz1_c0_stall", CW'(o_stall), 1);
    ex_regwrite = 0; ex_rd = 0; mem_regwrite = 1; mem_rd = 1;
    cycle("hz1_c1");
    chk("hz1_c1_fwd1", CW'(o_f1), 1);
    chk("hz1_c1_redirect", CW'(o_redirect), 1);
    chk("hz1_c1_cnt_stall", cnt_stall, 1);

    // bne x3,x4 after lw x4: two stalls, then MEM/WB forward
    do_reset();
    id_branch = 1; id_rs1 = 3; id_rs2 = 4; ex_regwrite = 1; ex_memread = 1; ex_rd = 4;
    cycle("hz2_c0");
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0; mem_regwrite = 1; mem_memread = 1; mem_rd = 4;
    cycle("hz2_c1");
    chk("hz2_c1_stall", CW'(o_stall), 1);
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0; wb_regwrite = 1; wb_rd = 4;
    cycle("hz2_c2");
    chk("hz2_c2_fwd2", CW'(o_f2), 2);
    chk("hz2_c2_stall", CW'(o_stall), 0);
    chk("hz2_c2_cnt_stall", cnt_stall, 2);
    idle_inputs();
    cycle("hz2_after");
    chk("hz2_cnt_branch", cnt_branch, 1);

    // jal ignores a pending load to x1
    do_reset();
    id_jal = 1; id_rs1 = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 1;
    cycle("jal");
    chk("jal_flush", CW'(o_flush), 1);
    idle_inputs();
    cycle("jal_after");
    chk("jal_cnt_branch", cnt_branch, 1);
    chk("jal_cnt_taken", cnt_taken, 1);

    // beq x0,x0 while something writes x0
    do_reset();
    id_branch = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 0; cmp_taken = 1;
    cycle("x0");
    chk("x0_redirect", CW'(o_redirect), 1);

    // Bus stall freezes a ready branch; it resolves exactly once afterwards
    do_reset();
    id_branch = 1; id_rs1 = 5; id_rs2 = 6; cmp_taken = 1; bus_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle("bus");
      chk("bus_redirect", CW'(o_redirect), 0);
    end
    bus_stall = 0;
    cycle("bus_drop");
    chk("bus_drop_redirect", CW'(o_redirect), 1);
    idle_inputs();
    cycle("bus_after");
    chk("bus_cnt_taken", cnt_taken, 1);

    // Reset in LDWAIT, then the same hazard stalls for two cycles again
    do_reset();
    id_branch = 1; id_rs1 = 7; ex_regwrite = 1; ex_memread = 1; ex_rd = 7;
    cycle("ldrst_c0");
    rst = 1;
    cycle("ldrst_rst");
    rst = 0;
    cycle("ldrst_c1");
    chk("ldrst_c1_stall", CW'(o_stall), 1);
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    cycle("ldrst_c2");
    chk("ldrst_c2_stall", CW'(o_stall), 1);
    cycle("ldrst_c3");
    chk("ldrst_c3_stall", CW'(o_stall), 0);
    chk("ldrst_cnt_stall", cnt_stall, 2);

    // Random traffic on a small register window to provoke dependencies
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int op;
      rst          = ($urandom_range(0, 99) < 2);
      bus_stall    = ($urandom_range(0, 99) < 15);
      op           = int'($urandom_range(0, 5));
      id_branch    = (op <= 1);
      id_jal       = (op == 2);
      id_jalr      = (op == 3);
      id_rs1       = RW'($urandom_range(0, 3));
      id_rs2       = RW'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = 1'($urandom_range(0, 1));
      ex_rd        = RW'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_memread  = 1'($urandom_range(0, 1));
      mem_rd       = RW'($urandom_range(0, 3));
      wb_regwrite  = 1'($urandom_range(0, 1));
      wb_rd        = RW'($urandom_range(0, 3));
      cmp_taken    = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
